l2_cache_ctrl_nway: RTL and testbench

Parametrised control FSM for the unified L2 cache, generalised to NUM_WAYS ways with explicit valid tracking.
- Sits between the L1 arbiter (mem_* side) and physical memory (pmem_* side).
- Drives datapath load enables as one-hot way vectors.
- Dirty victims are handed to the eviction write buffer (EWB) through a push/full handshake before the line fill.
- After a fill, the FSM re-enters CHECK, so every response comes from a hit cycle.

---
 rtl/lc3b_types.sv | 24 ++
 rtl/l2_victim_select.sv | 26 ++
 rtl/l2_cache_ctrl_nway.sv | 147 ++++++++++++++
 tb/tb_l2_cache_ctrl_nway.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types and L2 cache constants: tag type, controller state encoding
// and a saturating counter helper.
package lc3b_types;

    localparam int L2_NUM_WAYS    = 4;
    localparam int L2_OFFSET_BITS = 5;
    localparam int L2_INDEX_BITS  = 4;
    localparam int L2_TAG_BITS    = 16 - L2_INDEX_BITS - L2_OFFSET_BITS;

    typedef logic [15:0]            lc3b_word;
    typedef logic [L2_TAG_BITS-1:0] l2_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EVICT,
        FILL
    } l2_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/l2_victim_select.sv
// Combinational victim pick for the addressed set: the lowest-index invalid way wins,
// and LRU is used only when every way is valid.
module l2_victim_select
    import lc3b_types::*;
#(
    parameter  int NUM_WAYS = L2_NUM_WAYS,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-1:0] dirty_vec,
    input  logic [WAY_BITS-1:0] lru_way,
    output logic [WAY_BITS-1:0] victim_way,
    output logic                victim_dirty
);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        victim_way = lru_way;
        // Descending scan so the lowest invalid index is the last one written.
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) victim_way = WAY_BITS'(i);
        end
        victim_dirty = valid_vec[victim_way] & dirty_vec[victim_way];
    end

endmodule

// File: rtl/l2_cache_ctrl_nway.sv
// N-way L2 cache control FSM between the L1 arbiter and physical memory, with EWB hand-off.
// Optional macro L2_PERF_CNT_EN adds saturating hit/miss/evict counters.
module l2_cache_ctrl_nway
    import lc3b_types::*;
#(
    parameter  int NUM_WAYS    = L2_NUM_WAYS,
    parameter  int OFFSET_BITS = L2_OFFSET_BITS,
    parameter  int INDEX_BITS  = L2_INDEX_BITS,
    localparam int WAY_BITS    = $clog2(NUM_WAYS),
    localparam int TAG_BITS    = 16 - INDEX_BITS - OFFSET_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [15:0]         mem_address,
    output logic                mem_resp,
    input  logic                hit,
    input  logic [NUM_WAYS-1:0] hit_way,
    input  logic [WAY_BITS-1:0] lru_way,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-1:0] dirty_vec,
    input  logic [TAG_BITS-1:0] victim_tag,
    output logic [NUM_WAYS-1:0] ld_data,
    output logic                data_src_mem,
    output logic [NUM_WAYS-1:0] ld_valid,
    output logic [NUM_WAYS-1:0] ld_dirty,
    output logic                dirty_in,
    output logic                ld_lru,
    output logic                pmem_read,
    output logic [15:0]         pmem_address,
    input  logic                pmem_resp,
    input  logic                ewb_full,
    output logic                ewb_push,
    output logic [15:0]         ewb_address
`ifdef L2_PERF_CNT_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count,
    output logic [15:0]         evict_count
`endif
);

    l2_state_e             state, state_next;
    logic [WAY_BITS-1:0]   victim_q, victim_way;
    logic                  victim_dirty;
    logic [NUM_WAYS-1:0]   hit_sel, victim_oh;
    logic [INDEX_BITS-1:0] index;
    logic                  req;
    logic                  unused_offset;

    l2_victim_select #(.NUM_WAYS(NUM_WAYS)) u_victim_select (
        .valid_vec    (valid_vec),
        .dirty_vec    (dirty_vec),
        .lru_way      (lru_way),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty)
    );

    assign req           = mem_read | mem_write;
    assign index         = mem_address[OFFSET_BITS +: INDEX_BITS];
    assign unused_offset = ^mem_address[OFFSET_BITS-1:0];
    // Isolate the lowest set bit so a multi-hot hit_way still writes a single way.
    assign hit_sel       = hit_way & (~hit_way + NUM_WAYS'(1));
    assign victim_oh     = NUM_WAYS'(1) << victim_q;

    // NOTE: reset is synchronous and sampled on the clock edge; state uses non-blocking updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            victim_q <= '0;
        end else begin
            state <= state_next;
            if (state == CHECK) victim_q <= victim_way;
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        ld_data      = '0;
        data_src_mem = 1'b0;
        ld_valid     = '0;
        ld_dirty     = '0;
        dirty_in     = 1'b0;
        ld_lru       = 1'b0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        ewb_push     = 1'b0;
        ewb_address  = '0;
        case (state)
            IDLE: if (req) state_next = CHECK;
            CHECK: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    ld_lru     = 1'b1;
                    state_next = IDLE;
                    // A write wins when both request lines are high.
                    if (mem_write) begin
                        ld_data      = hit_sel;
                        data_src_mem = 1'b1;
                        ld_dirty     = hit_sel;
                        dirty_in     = 1'b1;
                    end
                end else begin
                    state_next = victim_dirty ? EVICT : FILL;
                end
            end
            EVICT: begin
                if (!ewb_full) begin
                    ewb_push    = 1'b1;
                    ewb_address = {victim_tag, index, {OFFSET_BITS{1'b0}}};
                    ld_dirty    = victim_oh;
                    state_next  = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    ld_data    = victim_oh;
                    ld_valid   = victim_oh;
                    ld_dirty   = victim_oh;
                    state_next = CHECK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef L2_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            evict_count <= '0;
        end else begin
            if (mem_resp) hit_count <= sat_inc16(hit_count);
            if (state == CHECK && state_next != IDLE) miss_count <= sat_inc16(miss_count);
            if (ewb_push) evict_count <= sat_inc16(evict_count);
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Self-checking bench for l2_cache_ctrl_nway: directed table, randomized transactions
// against a set-level model, and hand-written reset / abandoned-request sequences.
module tb_l2_cache_ctrl_nway;
    import lc3b_types::*;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_resp;
    logic [15:0] mem_address;
    logic        hit;
    logic [3:0]  hit_way, valid_vec, dirty_vec;
    logic [1:0]  lru_way;
    logic [6:0]  victim_tag;
    logic [3:0]  ld_data, ld_valid, ld_dirty;
    logic        data_src_mem, dirty_in, ld_lru, pmem_read, pmem_resp, ewb_full, ewb_push;
    logic [15:0] pmem_address, ewb_address;
`ifdef L2_PERF_CNT_EN
    logic [15:0] hit_count, miss_count, evict_count;
`endif

    always #5 clk = ~clk;

    l2_cache_ctrl_nway dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_resp     (mem_resp),
        .hit          (hit),
        .hit_way      (hit_way),
        .lru_way      (lru_way),
        .valid_vec    (valid_vec),
        .dirty_vec    (dirty_vec),
        .victim_tag   (victim_tag),
        .ld_data      (ld_data),
        .data_src_mem (data_src_mem),
        .ld_valid     (ld_valid),
        .ld_dirty     (ld_dirty),
        .dirty_in     (dirty_in),
        .ld_lru       (ld_lru),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .ewb_full     (ewb_full),
        .ewb_push     (ewb_push),
        .ewb_address  (ewb_address)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .evict_count  (evict_count)
`endif
    );

    typedef struct {
        logic        rd, wr;
        logic [15:0] addr;
        logic        hit;
        logic [3:0]  hit_way, valid, dirty;
        logic [1:0]  lru;
        logic [6:0]  vtag;
        int          stall, lat;
        int          e_lat, e_push;
        logic [15:0] e_ewb, e_pmem;
        logic [3:0]  e_fill, e_resp_ld;
        logic        e_din;
    } vec_t;

    int n_cmp = 0, n_fail = 0;
    int exp_hits = 0, exp_miss = 0, exp_evict = 0;
    int nresp, nfill, fcnt, waited;
    vec_t tbl[10];
    vec_t rv;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Set-level reference: which way gets replaced, whether it is written back, and timing.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   vic = int'(v.lru);
        int   lo = 0;
        logic ev;
        for (int i = NW - 1; i >= 0; i--) if (!v.valid[i]) vic = i;
        ev = v.valid[vic] & v.dirty[vic];
        r.e_din = v.wr;
        if (v.hit) begin
            for (int i = NW - 1; i >= 0; i--) if (v.hit_way[i]) lo = i;
            r.e_lat = 2; r.e_push = 0; r.e_fill = 4'b0; r.e_ewb = 16'h0; r.e_pmem = 16'h0;
            r.e_resp_ld = v.wr ? 4'(1 << lo) : 4'b0;
        end else begin
            r.e_fill    = 4'(1 << vic);
            r.e_push    = ev ? 1 : 0;
            r.e_lat     = 3 + v.lat + (ev ? 1 + v.stall : 0);
            r.e_ewb     = {v.vtag, v.addr[8:5], 5'b0};
            r.e_pmem    = {v.addr[15:5], 5'b0};
            r.e_resp_ld = v.wr ? r.e_fill : 4'b0;
        end
        return r;
    endfunction

    // Plays the L1, datapath, memory and EWB roles for one request; starts and ends at negedge.
    task automatic run_txn(input vec_t v, input string nm);
        int          fill_cnt = 0, push_cnt = 0, early = 0, lat = -1;
        logic [15:0] ewb_seen = '0, pmem_seen = '0;
        logic [3:0]  fill_seen = '0, resp_ld = '0, resp_dirty = '0, now_hw = v.hit_way;
        logic        resp_din = 1'b0, resp_lru = 1'b0, fill_src = 1'b1, now_hit = v.hit;
        mem_read = v.rd; mem_write = v.wr; mem_address = v.addr;
        valid_vec = v.valid; dirty_vec = v.dirty; lru_way = v.lru; victim_tag = v.vtag;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            hit       = now_hit;
            hit_way   = now_hw;
            ewb_full  = (cyc < 3 + v.stall);
            pmem_resp = pmem_read && (fill_cnt == v.lat - 1);
            if (pmem_read) fill_cnt++;
            #1;
            if (ewb_push) begin push_cnt++; ewb_seen = ewb_address; end
            if (pmem_read) begin
                pmem_seen = pmem_address;
                if (push_cnt == 0 && v.e_push != 0) early++;
            end
            if (ld_valid != 4'b0) begin
                fill_seen = ld_valid; fill_src = data_src_mem;
                now_hit = 1'b1; now_hw = ld_valid;
            end
            if (mem_resp) begin
                lat = cyc; resp_ld = ld_data; resp_dirty = ld_dirty;
                resp_din = dirty_in; resp_lru = ld_lru;
                break;
            end
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        if (lat < 0) begin
            check({nm, ":timeout"}, 32'd1, 32'd0);
            mem_read = 1'b0; mem_write = 1'b0; rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
        end else begin
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
            @(negedge clk);
        end
        exp_hits++;
        exp_miss  += (v.e_fill != 4'b0) ? 1 : 0;
        exp_evict += v.e_push;
        check({nm, ":latency"}, lat, v.e_lat);
        check({nm, ":push_count"}, push_cnt, v.e_push);
        if (v.e_push != 0) begin
            check({nm, ":ewb_address"}, ewb_seen, v.e_ewb);
            check({nm, ":pmem_before_push"}, early, 0);
        end
        if (v.e_fill != 4'b0) begin
            check({nm, ":pmem_address"}, pmem_seen, v.e_pmem);
            check({nm, ":fill_src"}, fill_src, 1'b0);
        end
        check({nm, ":fill_way"}, fill_seen, v.e_fill);
        check({nm, ":resp_ld_data"}, resp_ld, v.e_resp_ld);
        check({nm, ":resp_ld_dirty"}, resp_dirty, v.e_resp_ld);
        check({nm, ":resp_dirty_in"}, resp_din, v.e_din);
        check({nm, ":resp_ld_lru"}, resp_lru, 1'b1);
    endtask

    initial begin
        //        rd    wr    addr      hit   hway     valid    dirty    lru   vtag   st la  elat push ewb       pmem      fill     respld   din
        tbl[0] = '{1'b1, 1'b0, 16'h1240, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 7'h00, 0, 3, 6,  0, 16'h0000, 16'h1240, 4'b0001, 4'b0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'h1244, 1'b1, 4'b0100, 4'b1111, 4'b0000, 2'd0, 7'h00, 0, 1, 2,  0, 16'h0000, 16'h0000, 4'b0000, 4'b0100, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 16'h5A60, 1'b0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 7'h12, 0, 2, 6,  1, 16'h2460, 16'h5A60, 4'b0010, 4'b0000, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'h5A60, 1'b0, 4'b0000, 4'b1111, 4'b0010, 2'd1, 7'h12, 5, 2, 11, 1, 16'h2460, 16'h5A60, 4'b0010, 4'b0010, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 16'h3F9F, 1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 7'h55, 0, 4, 7,  0, 16'h0000, 16'h3F80, 4'b0100, 4'b0000, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 16'h0100, 1'b1, 4'b0110, 4'b1111, 4'b0000, 2'd3, 7'h00, 0, 1, 2,  0, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 16'h0200, 1'b1, 4'b1000, 4'b1111, 4'b0000, 2'd0, 7'h00, 0, 1, 2,  0, 16'h0000, 16'h0000, 4'b0000, 4'b1000, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 16'hFFE0, 1'b0, 4'b0000, 4'b0111, 4'b1000, 2'd1, 7'h7F, 0, 1, 4,  0, 16'h0000, 16'hFFE0, 4'b1000, 4'b0000, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 16'h8421, 1'b0, 4'b0000, 4'b1111, 4'b0111, 2'd3, 7'h01, 0, 2, 5,  0, 16'h0000, 16'h8420, 4'b1000, 4'b0000, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 16'hFFFF, 1'b0, 4'b0000, 4'b1111, 4'b0001, 2'd0, 7'h7F, 1, 1, 6,  1, 16'hFFE0, 16'hFFE0, 4'b0001, 4'b0000, 1'b0};

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
        hit = 1'b0; hit_way = '0; lru_way = '0; valid_vec = '0; dirty_vec = '0;
        victim_tag = '0; pmem_resp = 1'b0; ewb_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {mem_resp, ld_data, data_src_mem, ld_valid, ld_dirty, dirty_in, ld_lru, pmem_read, ewb_push},
              32'd0);
        check("reset_addresses", {pmem_address, ewb_address}, 32'd0);
`ifdef L2_PERF_CNT_EN
        check("reset_counters", {hit_count, miss_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv.rd = 1'($urandom_range(0, 1)); rv.wr = ~rv.rd | 1'($urandom_range(0, 1));
            rv.addr = 16'($urandom); rv.hit = ($urandom_range(0, 2) == 0);
            rv.hit_way = 4'($urandom_range(1, 15)); rv.valid = 4'($urandom);
            rv.dirty = 4'($urandom); rv.lru = 2'($urandom); rv.vtag = 7'($urandom);
            rv.stall = $urandom_range(0, 3); rv.lat = $urandom_range(1, 4);
            run_txn(model(rv), $sformatf("rnd%0d", i));
        end

        // Request abandoned mid-miss: the fill finishes but no response is given.
        mem_read = 1'b1; mem_address = 16'h4000; hit = 1'b0;
        valid_vec = 4'b0000; dirty_vec = 4'b0000; lru_way = 2'd0;
        nresp = 0; nfill = 0; fcnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) mem_read = 1'b0;
            pmem_resp = pmem_read && (fcnt == 2);
            if (pmem_read) fcnt++;
            #1;
            nresp += mem_resp ? 1 : 0;
            nfill += (ld_valid != 4'b0) ? 1 : 0;
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        exp_miss++;
        check("abandon:resp_count", nresp, 0);
        check("abandon:fill_count", nfill, 1);
        check("abandon:idle_pmem_read", pmem_read, 1'b0);
`ifdef L2_PERF_CNT_EN
        check("perf:hit_count", hit_count, exp_hits);
        check("perf:miss_count", miss_count, exp_miss);
        check("perf:evict_count", evict_count, exp_evict);
`endif

        // Reset while the fill is outstanding.
        mem_read = 1'b1; mem_address = 16'h2220; waited = 0;
        while (!pmem_read && waited < 10) begin @(negedge clk); waited++; end
        check("rst_fill:reached_fill", pmem_read, 1'b1);
        rst_n = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        check("rst_fill:pmem_read", pmem_read, 1'b0);
        check("rst_fill:outputs", {mem_resp, ld_data, ld_valid, ld_dirty, ewb_push, pmem_address}, 32'd0);
`ifdef L2_PERF_CNT_EN
        check("rst_fill:counters", {hit_count, miss_count}, 32'd0);
        check("rst_fill:evict_count", evict_count, 16'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_fill:stays_idle", {pmem_read, mem_resp}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
